// File: rtl/i2c_target_regfile.sv
// I2C target with a byte register file: oversampled SCL/SDA, 7-bit address match,
// auto-incrementing pointer for writes and reads, and a parallel host read port.
module i2c_target_regfile #(
  parameter logic [6:0] TGT_ADDR = 7'h02,
  parameter int         NREGS    = 16,
  parameter int         PW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  input  logic [PW-1:0] host_addr,
  output logic [7:0]    host_data,
  output logic          wr_pulse,
  output logic [PW-1:0] wr_idx,
  output logic          rd_pulse,
  output logic          busy,
  output logic          stop_det
);
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    rx_q, rx_d, tx_q, tx_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          rw_q, rw_d, busy_q, busy_d, sda_oe_q, sda_oe_d;
  logic [7:0]    regs_q [NREGS];
  logic [7:0]    regs_d [NREGS];

  logic          scl_now, sda_now, scl_rise, scl_fall, start_ev, stop_ev, byte_done;
  logic [7:0]    rx_byte, rd_cur, rd_next;
  logic [PW-1:0] ptr_inc;

  // Sync stages: [0] metastability catch, [1] synced value, [2] history for edges.
  assign scl_now   = scl_sync_q[1];
  assign sda_now   = sda_sync_q[1];
  assign scl_rise  = scl_now & ~scl_sync_q[2];
  assign scl_fall  = ~scl_now & scl_sync_q[2];
  assign start_ev  = scl_now & sda_sync_q[2] & ~sda_now;
  assign stop_ev   = scl_now & ~sda_sync_q[2] & sda_now;
  assign rx_byte   = {rx_q[6:0], sda_now};
  assign byte_done = scl_rise && (cnt_q == 4'd7);
  assign ptr_inc   = ptr_q + PW'(1);
  assign rd_cur    = regs_q[ptr_q];
  assign rd_next   = regs_q[ptr_inc];

  assign host_data = regs_q[host_addr];
  assign wr_idx    = ptr_q;
  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], scl_i};
    sda_sync_d = {sda_sync_q[1:0], sda_i};
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    sda_oe_d   = sda_oe_q;
    regs_d     = regs_q;
    wr_pulse   = 1'b0;
    rd_pulse   = 1'b0;
    stop_det   = 1'b0;

    if (stop_ev) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      stop_det = 1'b1;
    end else if (start_ev) begin
      state_d  = S_ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            rx_d  = rx_byte;
            cnt_d = cnt_q + 4'd1;
          end
          if (byte_done) begin
            cnt_d = '0;
            if (state_q == S_ADDR) begin
              if (rx_byte[7:1] == TGT_ADDR) begin
                state_d = S_ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = rx_byte[0];
              end else begin
                state_d = S_WAIT_STOP;
              end
            end else if (state_q == S_PTR) begin
              ptr_d   = rx_byte[PW-1:0];
              state_d = S_PTR_ACK;
            end else begin
              regs_d[ptr_q] = rx_byte;
              wr_pulse      = 1'b1;
              ptr_d         = ptr_inc;
              state_d       = S_WDATA_ACK;
            end
          end
        end
        // First fall after the byte starts the ACK; the next one ends it.
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              sda_oe_d = 1'b1;
              cnt_d    = 4'd1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              if (state_q == S_ADDR_ACK && rw_q) begin
                tx_d     = rd_cur;
                rd_pulse = 1'b1;
                sda_oe_d = ~rd_cur[7];
                state_d  = S_RDATA;
              end else if (state_q == S_ADDR_ACK) begin
                state_d = S_PTR;
              end else begin
                state_d = S_WDATA;
              end
            end
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = S_RDATA_ACK;
            end else if (cnt_q == 4'd0) begin
              sda_oe_d = ~tx_q[7];
            end else begin
              tx_d     = {tx_q[6:0], 1'b0};
              sda_oe_d = ~tx_q[6];
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) begin
            ptr_d = ptr_inc;
            if (!sda_now) begin
              tx_d     = rd_next;
              rd_pulse = 1'b1;
              cnt_d    = '0;
              state_d  = S_RDATA;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      // NOTE: the file is reset because the host port must read zeros after reset.
      regs_q     <= '{default: '0};
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      sda_oe_q   <= sda_oe_d;
      regs_q     <= regs_d;
    end
  end
endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: an I2C master model drives directed transactions;
// a register-file model plus a per-cycle compare process checks the host port and strobes.
module tb_i2c_target_regfile;
  localparam int Q = 5;  // clocks per quarter SCL period

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [3:0] host_addr = '0;
  logic       sda_oe, wr_pulse, rd_pulse, busy, stop_det, sda_bus;
  logic [7:0] host_data;
  logic [3:0] wr_idx;

  assign sda_bus = sda_m & ~sda_oe;  // open-drain wired-AND
  always #5 clk = ~clk;

  i2c_target_regfile #(.TGT_ADDR(7'h02), .NREGS(16), .PW(4)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
    .host_addr(host_addr), .host_data(host_data), .wr_pulse(wr_pulse), .wr_idx(wr_idx),
    .rd_pulse(rd_pulse), .busy(busy), .stop_det(stop_det)
  );

  typedef struct packed { logic [3:0] idx; logic [7:0] data; } wr_t;
  wr_t        exp_wr[$];
  logic [7:0] model_regs [16];
  logic [7:0] mirror [16];
  logic [3:0] exp_ptr = '0;
  int n_checks = 0, n_fail = 0;
  int wr_seen = 0, rd_seen = 0, stop_seen = 0;
  int exp_wr_cnt = 0, exp_rd = 0, exp_stops = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (!scl_m) begin
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
    end
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(2 * Q);
    exp_stops++;
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    b = sda_bus;  wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic nack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(nack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic send_ack(input string name, input logic [7:0] d);
    logic n;
    send_byte(d, n);
    check(name, n, 1'b0);
  endtask

  task automatic set_ptr(input logic [7:0] p);
    send_ack("ptr_ack", p);
    exp_ptr = p[3:0];
  endtask

  task automatic write_data(input logic [7:0] d);
    wr_t e;
    e.idx  = exp_ptr;
    e.data = d;
    exp_wr.push_back(e);
    model_regs[exp_ptr] = d;
    exp_ptr = exp_ptr + 4'd1;
    exp_wr_cnt++;
    send_ack("wdata_ack", d);
  endtask

  task automatic read_data(input logic nack, output logic [7:0] d);
    recv_byte(d, nack);
    check("rdata_model", d, model_regs[exp_ptr]);
    exp_ptr = exp_ptr + 4'd1;
    exp_rd++;
  endtask

  task automatic sweep_host();
    for (int i = 0; i < 16; i++) begin
      host_addr = 4'(i);
      wait_clk(1);
    end
  endtask

  task automatic peek(input string name, input logic [3:0] a, input logic [7:0] v);
    host_addr = a;
    wait_clk(1);
    check(name, host_data, v);
  endtask

  // Per-cycle compare: host port against the model file, write strobes against expected writes.
  initial begin : compare
    logic pending;
    wr_t  pend;
    wr_t  e;
    pending = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        for (int i = 0; i < 16; i++) mirror[i] = 8'h00;
        pending = 1'b0;
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pulses", {wr_pulse, rd_pulse, stop_det}, 3'b000);
      end else begin
        if (pending) begin
          mirror[pend.idx] = pend.data;
          pending = 1'b0;
        end
        check("host_data", host_data, mirror[host_addr]);
        if (wr_pulse) begin
          wr_seen++;
          if (exp_wr.size() == 0) begin
            check("wr_unexpected", wr_pulse, 1'b0);
          end else begin
            e = exp_wr.pop_front();
            check("wr_idx", wr_idx, e.idx);
            pend    = e;
            pending = 1'b1;
          end
        end
        if (rd_pulse) rd_seen++;
        if (stop_det) stop_seen++;
      end
    end
  end

  initial begin : watchdog
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: bench did not complete within cycle budget");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] d;
    logic       n;
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    wait_clk(4);
    check("reset_sda_oe", sda_oe, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst = 1'b1;
    wait_clk(4);
    for (int i = 0; i < 16; i++) peek("reset_reg", 4'(i), 8'h00);

    // Setup: reg4 = 0x44 so the pointer position after T2 is observable.
    bus_start(); send_ack("setup_addr", 8'h04); set_ptr(8'h04); write_data(8'h44); bus_stop();

    // T1: single write to reg3.
    bus_start();
    send_ack("t1_addr_ack", 8'h04);
    set_ptr(8'h03);
    write_data(8'hAA);
    check("t1_busy", busy, 1'b1);
    bus_stop();
    check("t1_busy_after_stop", busy, 1'b0);
    check("t1_stop_det", stop_seen, exp_stops);
    check("t1_wr_count", wr_seen, 2);
    peek("t1_reg3", 4'd3, 8'hAA);
    sweep_host();

    // T2: pointer write, repeated START, read with NACK; then a current-address read.
    bus_start();
    send_ack("t2_addr_w", 8'h04);
    set_ptr(8'h03);
    bus_start();
    send_ack("t2_addr_r", 8'h05);
    read_data(1'b1, d);
    check("t2_rdata", d, 8'hAA);
    bus_stop();
    bus_start();
    send_ack("t2_addr_cur", 8'h05);
    read_data(1'b1, d);
    check("t2_ptr_is_4", d, 8'h44);
    bus_stop();
    check("t2_rd_count", rd_seen, exp_rd);

    // T3: burst write across the wrap, pointer byte upper bits ignored, burst read back.
    bus_start();
    send_ack("t3_addr_w", 8'h04);
    set_ptr(8'hFF);
    write_data(8'h11);
    write_data(8'h22);
    bus_stop();
    peek("t3_reg15", 4'd15, 8'h11);
    peek("t3_reg0", 4'd0, 8'h22);
    bus_start();
    send_ack("t3_addr_w2", 8'h04);
    set_ptr(8'h0F);
    bus_start();
    send_ack("t3_addr_r", 8'h05);
    read_data(1'b0, d);
    check("t3_rd0", d, 8'h11);
    read_data(1'b1, d);
    check("t3_rd1", d, 8'h22);
    bus_stop();
    check("t3_rd_count", rd_seen, exp_rd);
    check("t3_wr_count", wr_seen, exp_wr_cnt);

    // T4: address miss -> NACK, no busy, no writes.
    bus_start();
    send_byte(8'h06, n);
    check("t4_addr_nack", n, 1'b1);
    check("t4_busy", busy, 1'b0);
    send_byte(8'h55, n);
    check("t4_data_nack", n, 1'b1);
    bus_stop();
    check("t4_wr_count", wr_seen, exp_wr_cnt);
    check("t4_busy_after", busy, 1'b0);

    // T5: STOP after 4 data bits aborts the byte; next transaction is normal.
    bus_start();
    send_ack("t5_addr", 8'h04);
    set_ptr(8'h02);
    write_bit(1'b1); write_bit(1'b1); write_bit(1'b0); write_bit(1'b0);
    bus_stop();
    check("t5_stop_det", stop_seen, exp_stops);
    check("t5_no_write", wr_seen, exp_wr_cnt);
    check("t5_busy", busy, 1'b0);
    bus_start();
    send_ack("t5_addr2", 8'h04);
    set_ptr(8'h02);
    write_data(8'h5A);
    bus_stop();
    peek("t5_reg2", 4'd2, 8'h5A);
    sweep_host();

    // T6: reset while the target drives a read bit low.
    bus_start();
    send_ack("t6_addr_w", 8'h04);
    set_ptr(8'h00);
    bus_start();
    send_ack("t6_addr_r", 8'h05);
    exp_rd++;
    check("t6_oe_driving", sda_oe, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t6_oe_released", sda_oe, 1'b0);
    wait_clk(1);
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_clk(3);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    exp_ptr = '0;
    wait_clk(3);
    check("t6_busy", busy, 1'b0);
    for (int i = 0; i < 16; i++) peek("t6_reg_zero", 4'(i), 8'h00);

    // Post-reset: normal write and read back.
    bus_start();
    send_ack("t6_post_w", 8'h04);
    set_ptr(8'h07);
    write_data(8'h3C);
    bus_stop();
    bus_start();
    send_ack("t6_post_w2", 8'h04);
    set_ptr(8'h07);
    bus_start();
    send_ack("t6_post_r", 8'h05);
    read_data(1'b1, d);
    check("t6_post_rdata", d, 8'h3C);
    bus_stop();
    sweep_host();

    check("final_wr_count", wr_seen, exp_wr_cnt);
    check("final_rd_count", rd_seen, exp_rd);
    check("final_stop_count", stop_seen, exp_stops);
    check("final_wr_queue", exp_wr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
